tile_map_buffer: RTL and testbench

- Parametrised, clocked, double-buffered tile-map frame store for the LED/VGA row driver.
- Game logic writes 6-bit colour tiles into a back bank; the display side fetches expanded pixel rows from a front bank.
- Banks swap at a frame boundary; on-demand clear; scale modes 1x/2x/4x with horizontal replication in storage and vertical replication on read.

---
 rtl/tile_map_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_map_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_buffer.sv
`default_nettype none
// =============================================================================
// tile_map_buffer : double-buffered tile-map frame store, 1x/2x/4x scaling
// Revision        : 1.0
// =============================================================================
module tile_map_buffer #(
  parameter int COLS     = 56,
  parameter int ROWS     = 32,
  parameter int PIX_BITS = 6,
  parameter int TILE_PX  = 15,
  parameter int PAD      = 24,
  parameter int ROW_W    = 9
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [1:0]                             mult,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [7:0]                             wr_x,
  input  logic [7:0]                             wr_y,
  input  logic [PIX_BITS-1:0]                    wr_data,
  output logic                                   wr_err,
  input  logic                                   clr_start,
  output logic                                   busy,
  input  logic                                   swap_req,
  input  logic                                   frame_start,
  output logic                                   swap_done,
  output logic                                   front_sel,
  input  logic                                   row_req,
  input  logic [ROW_W-1:0]                       row,
  output logic                                   row_valid,
  output logic [2*PAD+COLS*TILE_PX*PIX_BITS-1:0] row_data
);

  localparam int LINE_W  = COLS * PIX_BITS;
  localparam int TILE_W  = TILE_PX * PIX_BITS;
  localparam int OUT_W   = 2 * PAD + COLS * TILE_W;
  localparam int RADDR_W = $clog2(ROWS);

  localparam logic [RADDR_W-1:0] c_last_row = RADDR_W'(ROWS - 1);
  localparam logic [10:0]        c_rows_w   = 11'(ROWS);
  localparam logic [10:0]        c_cols_w   = 11'(COLS);
  localparam logic [ROW_W-1:0]   c_rows_r   = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0]   c_div1     = ROW_W'(TILE_PX);
  localparam logic [ROW_W-1:0]   c_div2     = ROW_W'(TILE_PX * 2);
  localparam logic [ROW_W-1:0]   c_div4     = ROW_W'(TILE_PX * 4);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              r_state;
  logic [RADDR_W-1:0]  r_clr_row;
  logic                r_busy;
  logic                r_wr_ready;
  logic                r_wr_err;
  logic [1:0]          r_back_mult;
  logic [1:0]          r_front_mult;
  logic                r_front_sel;
  logic                r_pend;
  logic                r_swap_done;
  logic                r_rd_req;
  logic                r_rd_bank;
  logic                r_rd_zero;
  logic [RADDR_W-1:0]  r_rd_row;
  logic                r_row_valid;
  logic [OUT_W-1:0]    r_row_data;
  logic [LINE_W-1:0]   r_bank [2][ROWS];

  logic                w_back;
  logic [2:0]          w_scale;
  logic [10:0]         w_x0;
  logic [10:0]         w_x_end;
  logic                w_wr_bad;
  logic                w_wr_ok;
  logic                w_swap_go;
  logic [RADDR_W-1:0]  w_wr_row;
  logic [LINE_W-1:0]   w_back_line;
  logic [LINE_W-1:0]   w_wline;
  logic [COLS-1:0]     w_hit;
  logic [ROW_W-1:0]    w_row_d;
  logic                w_rd_zero;
  logic [LINE_W-1:0]   w_front_line;
  logic [OUT_W-1:0]    w_expand;

  assign w_back    = ~r_front_sel;
  assign w_wr_row  = wr_y[RADDR_W-1:0];
  assign w_scale   = {1'b0, r_back_mult} + 3'd1;
  assign w_swap_go = r_pend && frame_start && (r_state == ST_IDLE);

  // First tile covered by the write: wr_x is in current scale units
  always_comb begin
    case (r_back_mult)
      2'd0:    w_x0 = {3'b000, wr_x};
      2'd1:    w_x0 = {2'b00, wr_x, 1'b0};
      default: w_x0 = {1'b0, wr_x, 2'b00};
    endcase
  end

  assign w_x_end  = w_x0 + {8'd0, w_scale};
  assign w_wr_bad = ({3'b000, wr_y} >= c_rows_w) || (w_x_end > c_cols_w) || (r_back_mult == 2'd2);
  assign w_wr_ok  = (r_state == ST_IDLE) && wr_valid && !w_wr_bad;

  assign w_back_line = r_bank[w_back][w_wr_row];

  for (genvar c = 0; c < COLS; c++) begin : g_wr_tile
    localparam logic [10:0] c_idx = 11'(c);
    assign w_hit[c] = (c_idx >= w_x0) && (c_idx < w_x_end);
    assign w_wline[c*PIX_BITS +: PIX_BITS] = w_hit[c] ? wr_data
                                                      : w_back_line[c*PIX_BITS +: PIX_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_clr_row    <= '0;
      r_busy       <= 1'b1;
      r_wr_ready   <= 1'b0;
      r_wr_err     <= 1'b0;
      r_back_mult  <= 2'd0;
      r_front_mult <= 2'd0;
      r_front_sel  <= 1'b0;
      r_pend       <= 1'b0;
      r_swap_done  <= 1'b0;
    end else begin
      r_wr_err    <= 1'b0;
      r_swap_done <= 1'b0;
      case (r_state)
        ST_INIT, ST_CLEAR: begin
          if (r_clr_row == c_last_row) begin
            r_state    <= ST_IDLE;
            r_clr_row  <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_clr_row <= r_clr_row + 1'b1;
          end
        end
        default: begin
          r_wr_err <= wr_valid && w_wr_bad;
          if (clr_start) begin
            r_state     <= ST_CLEAR;
            r_busy      <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_back_mult <= mult;
          end
        end
      endcase
      // A request arriving while a swap is already pending is absorbed
      if (w_swap_go) begin
        r_front_sel  <= ~r_front_sel;
        r_front_mult <= r_back_mult;
        r_pend       <= 1'b0;
        r_swap_done  <= 1'b1;
      end else if (swap_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Bank storage is not reset; INIT wipes it row by row instead
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_bank[0][r_clr_row] <= '0;
      r_bank[1][r_clr_row] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_bank[w_back][r_clr_row] <= '0;
    end else if (w_wr_ok) begin
      r_bank[w_back][w_wr_row] <= w_wline;
    end
  end

  always_comb begin
    case (r_front_mult)
      2'd0:    w_row_d = row / c_div1;
      2'd1:    w_row_d = row / c_div2;
      default: w_row_d = row / c_div4;
    endcase
  end

  assign w_rd_zero    = (w_row_d >= c_rows_r) || (r_front_mult == 2'd2);
  assign w_front_line = r_bank[r_rd_bank][r_rd_row];

  assign w_expand[PAD-1:0]          = '0;
  assign w_expand[OUT_W-1 -: PAD]   = '0;
  for (genvar c = 0; c < COLS; c++) begin : g_rd_tile
    for (genvar k = 0; k < TILE_PX; k++) begin : g_rd_rep
      assign w_expand[PAD + c*TILE_W + k*PIX_BITS +: PIX_BITS] =
        w_front_line[c*PIX_BITS +: PIX_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_req    <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_zero   <= 1'b0;
      r_rd_row    <= '0;
      r_row_valid <= 1'b0;
      r_row_data  <= '0;
    end else begin
      r_rd_req    <= row_req;
      r_rd_bank   <= r_front_sel;
      r_rd_zero   <= w_rd_zero;
      r_rd_row    <= w_row_d[RADDR_W-1:0];
      r_row_valid <= r_rd_req;
      if (r_rd_req) begin
        r_row_data <= r_rd_zero ? '0 : w_expand;
      end
    end
  end

  assign wr_ready  = r_wr_ready;
  assign busy      = r_busy;
  assign wr_err    = r_wr_err;
  assign swap_done = r_swap_done;
  assign front_sel = r_front_sel;
  assign row_valid = r_row_valid;
  assign row_data  = r_row_data;

endmodule
`default_nettype wire

// File: tb/tb_tile_map_buffer.sv
`default_nettype none
// =============================================================================
// tb_tile_map_buffer : directed bench with a tile-level reference model
// Revision           : 1.0
// =============================================================================
module tb_tile_map_buffer;

  localparam int COLS   = 56;
  localparam int ROWS   = 32;
  localparam int PB     = 6;
  localparam int TPX    = 15;
  localparam int PAD    = 24;
  localparam int ROW_W  = 9;
  localparam int TILE_W = TPX * PB;
  localparam int OUT_W  = 2 * PAD + COLS * TILE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mult = 2'd0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [7:0]        wr_x = 8'd0;
  logic [7:0]        wr_y = 8'd0;
  logic [PB-1:0]     wr_data = '0;
  logic              wr_err;
  logic              clr_start = 1'b0;
  logic              busy;
  logic              swap_req = 1'b0;
  logic              frame_start = 1'b0;
  logic              swap_done;
  logic              front_sel;
  logic              row_req = 1'b0;
  logic [ROW_W-1:0]  row = '0;
  logic              row_valid;
  logic [OUT_W-1:0]  row_data;

  always #5 clk = ~clk;

  tile_map_buffer dut (
    .clk(clk), .rst(rst), .mult(mult),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_err(wr_err), .clr_start(clr_start), .busy(busy),
    .swap_req(swap_req), .frame_start(frame_start), .swap_done(swap_done),
    .front_sel(front_sel), .row_req(row_req), .row(row),
    .row_valid(row_valid), .row_data(row_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tiles per bank/row/column, plus frame-store bookkeeping
  logic [PB-1:0]    m_bank [2][ROWS][COLS];
  int               m_clear_left;
  bit               m_init;
  int               m_front;
  int               m_bm;
  int               m_fm;
  bit               m_pend;
  bit               s1_req;
  bit               s1_zero;
  int               s1_bank;
  int               s1_rowd;
  bit               e_err;
  bit               e_swap;
  bit               e_rv;
  logic [OUT_W-1:0] e_row;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    int idx;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      idx = -1;
      for (int i = 0; i < OUT_W; i++) begin
        if (got[i] !== exp[i]) begin
          idx = i;
          break;
        end
      end
      $display("FAIL %s: first differing bit %0d got %0b expected %0b", name, idx, got[idx], exp[idx]);
    end
  endtask

  function automatic int scale_of(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : (m == 3) ? 4 : 3;
  endfunction

  function automatic logic [OUT_W-1:0] expand_row(input int b, input int r);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < TPX; k++)
        v[PAD + c*TILE_W + k*PB +: PB] = m_bank[b][r][c];
    return v;
  endfunction

  task automatic model_reset();
    m_clear_left = ROWS;
    m_init       = 1'b1;
    m_front      = 0;
    m_bm         = 0;
    m_fm         = 0;
    m_pend       = 1'b0;
    s1_req       = 1'b0;
    e_err        = 1'b0;
    e_swap       = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then compare
  task automatic tick();
    bit idle;
    int s, x0, r;
    idle = (m_clear_left == 0);
    e_rv = s1_req;
    if (s1_req) e_row = s1_zero ? '0 : expand_row(s1_bank, s1_rowd);
    s       = scale_of(m_fm);
    s1_req  = row_req;
    s1_bank = m_front;
    s1_rowd = int'(row) / (TPX * s);
    s1_zero = (s1_rowd >= ROWS) || (m_fm == 2);
    e_err   = 1'b0;
    e_swap  = 1'b0;
    if (idle) begin
      if (wr_valid) begin
        s  = scale_of(m_bm);
        x0 = int'(wr_x) * s;
        if (int'(wr_y) >= ROWS || x0 + s > COLS || m_bm == 2) e_err = 1'b1;
        else for (int t = x0; t < x0 + s; t++) m_bank[1-m_front][int'(wr_y)][t] = wr_data;
      end
      if (clr_start) begin
        m_bm         = int'(mult);
        m_clear_left = ROWS;
        m_init       = 1'b0;
      end
    end else begin
      r = ROWS - m_clear_left;
      for (int c = 0; c < COLS; c++) begin
        m_bank[1-m_front][r][c] = '0;
        if (m_init) m_bank[m_front][r][c] = '0;
      end
      m_clear_left--;
    end
    if (m_pend && frame_start && idle) begin
      m_front = 1 - m_front;
      m_fm    = m_bm;
      m_pend  = 1'b0;
      e_swap  = 1'b1;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    chk1("busy", busy, m_clear_left != 0);
    chk1("wr_ready", wr_ready, m_clear_left == 0);
    chk1("front_sel", front_sel, m_front == 1);
    chk1("swap_done", swap_done, e_swap);
    chk1("wr_err", wr_err, e_err);
    chk1("row_valid", row_valid, e_rv);
    if (e_rv) chk_row("row_data", row_data, e_row);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk1("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_clear(input logic [1:0] m);
    mult = m; clr_start = 1'b1; tick(); clr_start = 1'b0;
    wait_idle();
  endtask

  task automatic do_write(input int x, input int y, input logic [PB-1:0] d);
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic do_read(input int r);
    row_req = 1'b1; row = ROW_W'(r); tick(); row_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [OUT_W-1:0] v;
    int n, nsw, isw, nv;
    int rows_q [4];

    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m_bank[b][r][c] = '0;
    model_reset();

    // Reset held 40 cycles, then INIT must last exactly ROWS cycles
    repeat (40) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk_int("init_len", n, 32);
    do_read(0);
    chk1("rd0_valid", row_valid, 1'b1);
    chk_row("rd0_data", row_data, '0);

    // 1x single tile, swap, read inside and just past the tile band
    do_clear(2'd0);
    do_write(0, 0, 6'h3F);
    do_swap();
    chk1("swap_pulse", swap_done, 1'b1);
    chk1("front_after_swap", front_sel, 1'b1);
    do_read(14);
    v = '0;
    v[113:24] = '1;
    chk_row("row14", row_data, v);
    do_read(15);
    chk_row("row15", row_data, '0);

    // 2x: write at the right edge, pipelined reads across the scaled band
    do_clear(2'd1);
    do_write(27, 1, 6'h15);
    do_swap();
    for (int r = 30; r < 60; r++) begin
      row_req = 1'b1; row = ROW_W'(r); tick();
    end
    row_req = 1'b0;
    tick();
    v = '0;
    for (int k = 0; k < 30; k++) v[4884 + k*6 +: 6] = 6'h15;
    chk_row("row59_2x", row_data, v);
    do_write(28, 1, 6'h2A);
    chk1("wr_err_pulse", wr_err, 1'b1);
    tick();

    // Swap requested during CLEAR waits for the first frame_start after it
    mult = 2'd0; clr_start = 1'b1; tick(); clr_start = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    nsw = 0; isw = -1;
    for (int i = 0; i < 60; i++) begin
      frame_start = (i % 10 == 0);
      tick();
      if (swap_done) begin
        nsw++;
        isw = i;
      end
    end
    frame_start = 1'b0;
    chk_int("clr_swap_count", nsw, 1);
    chk_int("clr_swap_cycle", isw, 40);
    chk1("clr_swap_front", front_sel, 1'b1);

    // Back-to-back reads including the last valid row and one past it
    do_write(0, 0, 6'h01);
    do_write(55, 31, 6'h2A);
    do_write(10, 1, 6'h07);
    do_swap();
    rows_q = '{0, 15, 479, 480};
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      row_req = 1'b1; row = ROW_W'(rows_q[i]); tick();
      if (row_valid) nv++;
    end
    row_req = 1'b0;
    tick();
    if (row_valid) nv++;
    chk_int("b2b_valids", nv, 4);
    chk_row("row480", row_data, '0);
    do_read(479);
    v = '0;
    for (int k = 0; k < 15; k++) v[4974 + k*6 +: 6] = 6'h2A;
    chk_row("row479", row_data, v);

    // Async reset mid-CLEAR with a swap pending
    do_swap();
    chk1("pre_rst_front", front_sel, 1'b1);
    mult = 2'd0; clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (3) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    row_req = 1'b1; row = '0; tick(); row_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_wr_ready", wr_ready, 1'b0);
    chk1("arst_busy", busy, 1'b1);
    chk1("arst_wr_err", wr_err, 1'b0);
    chk1("arst_swap_done", swap_done, 1'b0);
    chk1("arst_row_valid", row_valid, 1'b0);
    chk1("arst_front_sel", front_sel, 1'b0);
    chk_row("arst_row_data", row_data, '0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    frame_start = 1'b1;
    n = 0; nsw = 0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (swap_done) nsw++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (swap_done) nsw++;
    end
    frame_start = 1'b0;
    chk_int("init_len_after_arst", n, 32);
    chk_int("no_swap_after_arst", nsw, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
